// File: rtl/ext_bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared types and defaults for the external bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_bus_pkg;

    localparam int c_def_addr_w      = 13;
    localparam int c_def_data_w      = 8;
    localparam int c_def_sync_stages = 2;
    localparam int c_def_rd_timeout  = 15;
    localparam int c_wait_cnt_w      = 8;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } bridge_state_t;

endpackage : ext_bus_pkg
`default_nettype wire

// File: rtl/sync_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_cell
// Description : Multi-flop shift synchroniser with a parametrised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_cell #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule : sync_cell
`default_nettype wire

// File: rtl/ext_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ext_bus_bridge
// Description : Asynchronous SRAM-style bus to fabric bridge: synchronised
//               strobes, single-cycle write pulses, handshaked reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_bus_bridge
    import ext_bus_pkg::*;
#(
    parameter int ADDR_W      = c_def_addr_w,
    parameter int DATA_W      = c_def_data_w,
    parameter int SYNC_STAGES = c_def_sync_stages,
    parameter int RD_TIMEOUT  = c_def_rd_timeout
) (
    input  logic              clk,
    input  logic              nreset,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              nwe,
    input  logic              ncs,
    input  logic              noe,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_valid,
    output logic              rd_miss,
    output logic              busy
);

    localparam int                      c_ad_w      = ADDR_W + DATA_W;
    localparam logic [c_wait_cnt_w-1:0] c_timeout   = c_wait_cnt_w'(RD_TIMEOUT);
    localparam logic [c_wait_cnt_w-1:0] c_cnt_max   = '1;

    logic [2:0]              w_ctl_sync;
    logic                    w_ncs_s;
    logic                    w_nwe_s;
    logic                    w_noe_s;
    logic                    w_acc_s;
    logic [c_ad_w-1:0]       w_ad_sync;
    logic [c_ad_w-1:0]       r_ad_d;
    logic                    r_ncs_d;
    logic                    r_nwe_d;
    logic                    r_acc_d;
    logic                    w_wr_det;
    logic                    w_rd_det;
    logic                    w_drive;

    bridge_state_t           r_state;
    bridge_state_t           w_state_nxt;
    logic [c_wait_cnt_w-1:0] r_wait_cnt;
    logic [c_wait_cnt_w-1:0] w_cnt_inc;
    logic [c_wait_cnt_w-1:0] w_cnt_nxt;
    logic                    w_rd_req_nxt;
    logic                    w_miss_nxt;
    logic                    w_hold_ld;
    logic [DATA_W-1:0]       r_hold;

    sync_cell #(
        .WIDTH   (3),
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (3'b111)
    ) u_ctl_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      ({ncs, nwe, noe}),
        .q      (w_ctl_sync)
    );

    sync_cell #(
        .WIDTH   (c_ad_w),
        .DEPTH   (SYNC_STAGES),
        .RST_VAL ('0)
    ) u_ad_sync (
        .clk    (clk),
        .nreset (nreset),
        .d      ({addr, data}),
        .q      (w_ad_sync)
    );

    assign {w_ncs_s, w_nwe_s, w_noe_s} = w_ctl_sync;
    assign w_acc_s = w_ncs_s | w_noe_s;

    // r_ad_d is the extra address/data stage, aligned with the previous control sample
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ad_d  <= '0;
            r_ncs_d <= 1'b1;
            r_nwe_d <= 1'b1;
            r_acc_d <= 1'b1;
        end else begin
            r_ad_d  <= w_ad_sync;
            r_ncs_d <= w_ncs_s;
            r_nwe_d <= w_nwe_s;
            r_acc_d <= w_acc_s;
        end
    end

    // End of a write access: previous sample was a write, current one is not.
    assign w_wr_det = ~r_ncs_d & ~r_nwe_d & (w_ncs_s | w_nwe_s);
    assign w_rd_det = r_acc_d & ~w_acc_s & w_nwe_s;

    assign w_cnt_inc = (r_wait_cnt == c_cnt_max) ? r_wait_cnt : r_wait_cnt + 1'b1;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_wait_cnt;
        w_rd_req_nxt = 1'b0;
        w_miss_nxt   = 1'b0;
        w_hold_ld    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rd_det) begin
                    w_state_nxt  = RD_WAIT;
                    w_rd_req_nxt = 1'b1;
                end
            end
            RD_WAIT: begin
                w_cnt_nxt = w_cnt_inc;
                if (rd_valid) begin
                    w_state_nxt = IDLE;
                    w_hold_ld   = 1'b1;
                end else if ((w_cnt_inc == c_timeout) || w_acc_s) begin
                    w_state_nxt = IDLE;
                    w_miss_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            wr_strobe  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            rd_miss    <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            wr_strobe  <= w_wr_det;
            rd_req     <= w_rd_req_nxt;
            rd_miss    <= w_miss_nxt;
            if (w_wr_det) begin
                {wr_addr, wr_data} <= r_ad_d;
            end
            if (w_rd_req_nxt) begin
                rd_addr <= w_ad_sync[c_ad_w-1:DATA_W];
            end
            if (w_hold_ld) begin
                r_hold <= rd_data;
            end
        end
    end

    assign busy = (r_state == RD_WAIT);

    // Output enable follows the raw pins so the bus turns around without sync delay.
    assign w_drive = nreset & ~ncs & ~noe;
    assign data    = w_drive ? r_hold : {DATA_W{1'bz}};

endmodule : ext_bus_bridge
`default_nettype wire

// File: tb/tb_ext_bus_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ext_bus_bridge
// Description : Directed self-checking bench for ext_bus_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_bus_bridge;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic              clk;
    logic              nreset;
    logic [ADDR_W-1:0] addr;
    logic              nwe;
    logic              ncs;
    logic              noe;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_miss;
    logic              busy;
    logic              tb_en;
    logic [DATA_W-1:0] tb_val;
    wire  [DATA_W-1:0] data_bus;

    assign data_bus = tb_en ? tb_val : {DATA_W{1'bz}};

    // Pull-ups make an undriven bus read as all ones.
    for (genvar i = 0; i < DATA_W; i++) begin : g_pu
        pullup (data_bus[i]);
    end

    ext_bus_bridge #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .RD_TIMEOUT  (4)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .data      (data_bus),
        .addr      (addr),
        .nwe       (nwe),
        .ncs       (ncs),
        .noe       (noe),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_miss   (rd_miss),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_wr, n_rq, n_miss, n_busy;
    int wr_cyc, rq_cyc, miss_cyc;
    logic [ADDR_W-1:0] cap_wa, cap_ra;
    logic [DATA_W-1:0] cap_wd;

    // Event monitor, sampled 2 ns after each rising edge.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (wr_strobe) begin
            n_wr++;
            wr_cyc = cyc;
            cap_wa = wr_addr;
            cap_wd = wr_data;
        end
        if (rd_req) begin
            n_rq++;
            rq_cyc = cyc;
            cap_ra = rd_addr;
        end
        if (rd_miss) begin
            n_miss++;
            miss_cyc = cyc;
        end
        if (busy) n_busy++;
    end

    task automatic clr();
        n_wr = 0; n_rq = 0; n_miss = 0; n_busy = 0;
        wr_cyc = -100; rq_cyc = -100; miss_cyc = -100;
        cap_wa = '0; cap_ra = '0; cap_wd = '0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_rq(input string nm);
        int k;
        k = 0;
        while (n_rq == 0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        check(nm, 32'(n_rq > 0), 32'd1);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
        int                mode;      // 0: nWE first, 1: nCS first, 2: together
        int                nlow;
        bit                noe_low;
        int                exp_cnt;
        int                exp_lat;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } wvec_t;

    wvec_t wv [5];

    task automatic run_write(input int idx, input wvec_t v);
        int rel;
        @(negedge clk);
        clr();
        addr   = v.addr;
        tb_val = v.dat;
        tb_en  = 1'b1;
        ncs    = 1'b0;
        nwe    = 1'b0;
        noe    = v.noe_low ? 1'b0 : 1'b1;
        repeat (v.nlow) @(negedge clk);
        rel = cyc;
        case (v.mode)
            0:       nwe = 1'b1;
            1:       ncs = 1'b1;
            default: begin ncs = 1'b1; nwe = 1'b1; end
        endcase
        addr   = ~v.addr;
        tb_val = ~v.dat;
        noe    = 1'b1;
        @(negedge clk);
        ncs   = 1'b1;
        nwe   = 1'b1;
        tb_en = 1'b0;
        repeat (8) @(negedge clk);
        check($sformatf("w%0d_count", idx), n_wr, v.exp_cnt);
        check($sformatf("w%0d_latency", idx), wr_cyc - rel, v.exp_lat);
        check($sformatf("w%0d_addr", idx), 32'(cap_wa), 32'(v.exp_addr));
        check($sformatf("w%0d_data", idx), 32'(cap_wd), 32'(v.exp_data));
        check($sformatf("w%0d_no_rdreq", idx), n_rq, 0);
        check($sformatf("w%0d_no_miss", idx), n_miss, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel;

        wv[0] = '{13'h0A5,  8'h3C, 0, 6, 1'b0, 1, 3, 13'h0A5,  8'h3C};
        wv[1] = '{13'h1FFF, 8'hFF, 1, 3, 1'b0, 1, 3, 13'h1FFF, 8'hFF};
        wv[2] = '{13'h000,  8'h42, 2, 2, 1'b0, 1, 3, 13'h000,  8'h42};
        wv[3] = '{13'h0AAA, 8'h81, 2, 1, 1'b0, 1, 3, 13'h0AAA, 8'h81};
        wv[4] = '{13'h1C3,  8'h00, 0, 4, 1'b1, 1, 3, 13'h1C3,  8'h00};

        nreset = 1'b0; ncs = 1'b0; nwe = 1'b1; noe = 1'b0;
        addr = '0; tb_en = 1'b0; tb_val = '0; rd_valid = 1'b0; rd_data = '0;
        clr();
        repeat (3) @(negedge clk);
        check("rst_data_hiz", 32'(data_bus), 32'hFF);
        check("rst_wr_strobe", 32'(wr_strobe), 0);
        check("rst_rd_req", 32'(rd_req), 0);
        check("rst_rd_miss", 32'(rd_miss), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        ncs = 1'b1; noe = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_write(i, wv[i]);
        end

        // Read answered one cycle after the request.
        @(negedge clk);
        clr();
        addr = 13'h123; ncs = 1'b0; noe = 1'b0; nwe = 1'b1;
        rel = cyc;
        wait_rq("rd_req_seen");
        @(negedge clk);
        rd_valid = 1'b1; rd_data = 8'hE7;
        @(negedge clk);
        rd_valid = 1'b0; rd_data = 8'h00;
        @(negedge clk);
        check("rd_latency", rq_cyc - rel, 3);
        check("rd_addr", 32'(cap_ra), 32'h123);
        check("rd_busy_cycles", n_busy, 2);
        check("rd_data_bus", 32'(data_bus), 32'hE7);
        rd_valid = 1'b1; rd_data = 8'h11;
        @(negedge clk);
        rd_valid = 1'b0; rd_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rd_valid_idle_ignored", 32'(data_bus), 32'hE7);
        ncs = 1'b1; noe = 1'b1;
        #1;
        check("rd_release_hiz", 32'(data_bus), 32'hFF);
        repeat (5) @(negedge clk);
        check("rd_no_miss", n_miss, 0);
        check("rd_single_req", n_rq, 1);

        // No response: timeout.
        @(negedge clk);
        clr();
        addr = 13'h0F0; ncs = 1'b0; noe = 1'b0;
        wait_rq("to_req_seen");
        repeat (6) @(negedge clk);
        check("to_miss_count", n_miss, 1);
        check("to_miss_delay", miss_cyc - rq_cyc, 4);
        check("to_busy_cycles", n_busy, 4);
        check("to_hold_kept", 32'(data_bus), 32'hE7);
        ncs = 1'b1; noe = 1'b1;
        repeat (6) @(negedge clk);

        // nOE released before any response.
        clr();
        addr = 13'h055; ncs = 1'b0; noe = 1'b0;
        wait_rq("ab_req_seen");
        noe = 1'b1;
        repeat (5) @(negedge clk);
        rd_valid = 1'b1; rd_data = 8'h99;
        @(negedge clk);
        rd_valid = 1'b0; rd_data = 8'h00;
        @(negedge clk);
        check("ab_miss_count", n_miss, 1);
        check("ab_miss_delay", miss_cyc - rq_cyc, 3);
        check("ab_busy_cycles", n_busy, 3);
        check("ab_no_write", n_wr, 0);
        noe = 1'b0;
        #1;
        check("ab_late_valid_ignored", 32'(data_bus), 32'hE7);
        @(negedge clk);
        ncs = 1'b1; noe = 1'b1;
        repeat (8) @(negedge clk);

        // Reset asserted while waiting for a response.
        clr();
        addr = 13'h0AB; ncs = 1'b0; noe = 1'b0;
        wait_rq("mr_req_seen");
        @(negedge clk);
        check("mr_busy_before", 32'(busy), 1);
        nreset = 1'b0;
        #1;
        check("mr_data_hiz", 32'(data_bus), 32'hFF);
        check("mr_busy", 32'(busy), 0);
        check("mr_rd_req", 32'(rd_req), 0);
        check("mr_rd_miss", 32'(rd_miss), 0);
        check("mr_wr_strobe", 32'(wr_strobe), 0);
        check("mr_rd_addr", 32'(rd_addr), 0);
        check("mr_wr_addr", 32'(wr_addr), 0);
        check("mr_wr_data", 32'(wr_data), 0);
        @(negedge clk);
        ncs = 1'b1; noe = 1'b1; nreset = 1'b1;
        clr();
        repeat (6) @(negedge clk);
        check("mr_idle_after", 32'(busy), 0);
        check("mr_no_req_after", n_rq, 0);
        check("mr_no_miss_after", n_miss, 0);
        ncs = 1'b0; noe = 1'b0;
        #1;
        check("mr_hold_cleared", 32'(data_bus), 32'h00);
        @(negedge clk);
        ncs = 1'b1; noe = 1'b1;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ext_bus_bridge
`default_nettype wire
